// File: rtl/riscv_perf_monitor.sv
// Performance statistics beside a RISC-V core: cycle, branch and misprediction
// counters (global and per watched PC), end-of-run detection and a read port.
module riscv_perf_monitor #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   START,
  input  logic                   MEM_WR_EN,
  input  logic                   BR_VALID,
  input  logic [ADDR_W-1:0]      BR_PC,
  input  logic                   BR_MISPRED,
  input  logic [N_CH*ADDR_W-1:0] CH_PC,
  input  logic [N_CH-1:0]        CH_EN,
  input  logic                   RD_REQ,
  input  logic [IDX_W-1:0]       RD_IDX,
  output logic                   RD_ACK,
  output logic [CNT_W-1:0]       RD_BR,
  output logic [CNT_W-1:0]       RD_MISS,
  output logic [CNT_W-1:0]       CYCLES,
  output logic [CNT_W-1:0]       TOTAL_BR,
  output logic [CNT_W-1:0]       TOTAL_MISS,
  output logic [1:0]             STATE,
  output logic                   DONE_P,
  output logic                   OVF
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             done_d;
  logic             hist_q;
  logic             run_cnt;
  logic             ovf_d;
  logic [CNT_W-1:0] cycles_q, tbr_q, tmiss_q;
  logic [CNT_W-1:0] cycles_d, tbr_d, tmiss_d;
  logic [CNT_W-1:0] ch_br_q   [N_CH];
  logic [CNT_W-1:0] ch_miss_q [N_CH];
  logic [CNT_W-1:0] ch_br_d   [N_CH];
  logic [CNT_W-1:0] ch_miss_d [N_CH];
  logic [CNT_W:0]   r_cyc, r_tbr, r_tmiss;
  logic [CNT_W:0]   r_chb [N_CH];
  logic [CNT_W:0]   r_chm [N_CH];
  logic [CNT_W-1:0] rd_br_d, rd_miss_d;

  // Returns {reached_max, next}; the counter sticks at CNT_MAX.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v,
                                             input logic en);
    logic [CNT_W-1:0] nxt;
    logic             hit;
    nxt = v;
    hit = 1'b0;
    if (en && (v != CNT_MAX)) begin
      nxt = v + CNT_ONE;
      hit = (v == (CNT_MAX - CNT_ONE));
    end
    return {hit, nxt};
  endfunction

  // START overrides everything, including a falling edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (START) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN && hist_q && !MEM_WR_EN) begin
      state_d = S_DONE;
      done_d  = 1'b1;
    end
  end

  assign run_cnt = (state_q == S_RUN) && !START;

  always_comb begin
    r_cyc   = sat_inc(cycles_q, run_cnt);
    r_tbr   = sat_inc(tbr_q, run_cnt && BR_VALID);
    r_tmiss = sat_inc(tmiss_q, run_cnt && BR_VALID && BR_MISPRED);
    ovf_d   = ovf_q_or_hits();
    for (int k = 0; k < N_CH; k++) begin
      r_chb[k] = sat_inc(ch_br_q[k], run_cnt && BR_VALID && CH_EN[k] &&
                         (BR_PC == CH_PC[k*ADDR_W +: ADDR_W]));
      r_chm[k] = sat_inc(ch_miss_q[k], run_cnt && BR_VALID && BR_MISPRED && CH_EN[k] &&
                         (BR_PC == CH_PC[k*ADDR_W +: ADDR_W]));
      ovf_d    = ovf_d | r_chb[k][CNT_W] | r_chm[k][CNT_W];
    end
    cycles_d = r_cyc[CNT_W-1:0];
    tbr_d    = r_tbr[CNT_W-1:0];
    tmiss_d  = r_tmiss[CNT_W-1:0];
    for (int k = 0; k < N_CH; k++) begin
      ch_br_d[k]   = r_chb[k][CNT_W-1:0];
      ch_miss_d[k] = r_chm[k][CNT_W-1:0];
    end
    if (START) begin
      cycles_d = '0;
      tbr_d    = '0;
      tmiss_d  = '0;
      ovf_d    = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        ch_br_d[k]   = '0;
        ch_miss_d[k] = '0;
      end
    end
  end

  function automatic logic ovf_q_or_hits();
    return OVF | r_cyc[CNT_W] | r_tbr[CNT_W] | r_tmiss[CNT_W];
  endfunction

  // Unknown channel indices read as zero.
  always_comb begin
    rd_br_d   = '0;
    rd_miss_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (RD_IDX == IDX_W'(k)) begin
        rd_br_d   = ch_br_q[k];
        rd_miss_d = ch_miss_q[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= S_IDLE;
      DONE_P   <= 1'b0;
      hist_q   <= 1'b0;
      OVF      <= 1'b0;
      cycles_q <= '0;
      tbr_q    <= '0;
      tmiss_q  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        ch_br_q[k]   <= '0;
        ch_miss_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      DONE_P   <= done_d;
      hist_q   <= MEM_WR_EN;
      OVF      <= ovf_d;
      cycles_q <= cycles_d;
      tbr_q    <= tbr_d;
      tmiss_q  <= tmiss_d;
      for (int k = 0; k < N_CH; k++) begin
        ch_br_q[k]   <= ch_br_d[k];
        ch_miss_q[k] <= ch_miss_d[k];
      end
    end
  end

  // Handshake: every RD_REQ sampled high is answered by exactly one RD_ACK
  // pulse on the next cycle; there is no ready/backpressure. Data holds between acks.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      RD_ACK  <= 1'b0;
      RD_BR   <= '0;
      RD_MISS <= '0;
    end else begin
      RD_ACK <= RD_REQ;
      if (RD_REQ) begin
        RD_BR   <= rd_br_d;
        RD_MISS <= rd_miss_d;
      end
    end
  end

  assign STATE      = state_q;
  assign CYCLES     = cycles_q;
  assign TOTAL_BR   = tbr_q;
  assign TOTAL_MISS = tmiss_q;

endmodule

// File: tb/tb_riscv_perf_monitor.sv
// Self-checking bench for riscv_perf_monitor: vector table for branch accounting,
// queued read expectations, and directed sequences for run end, restart and reset.
module tb_riscv_perf_monitor;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 32;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 4;

  logic                   clk;
  logic                   rstn;
  logic                   start;
  logic                   mem_wr_en;
  logic                   br_valid;
  logic [ADDR_W-1:0]      br_pc;
  logic                   br_mispred;
  logic [N_CH*ADDR_W-1:0] ch_pc;
  logic [N_CH-1:0]        ch_en;
  logic                   rd_req;
  logic [IDX_W-1:0]       rd_idx;
  logic                   rd_ack;
  logic [CNT_W-1:0]       rd_br, rd_miss, cycles, total_br, total_miss;
  logic [1:0]             state;
  logic                   done_p, ovf;

  logic                   s_rd_ack, s_done_p, s_ovf;
  logic [3:0]             s_rd_br, s_rd_miss, s_cycles, s_total_br, s_total_miss;
  logic [1:0]             s_state;

  int checks   = 0;
  int failures = 0;

  logic [2*CNT_W-1:0] exp_q[$];

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        mis;
    logic [31:0] exp_br;
    logic [31:0] exp_miss;
  } br_vec_t;

  br_vec_t vecs[15];

  riscv_perf_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .CLK(clk), .RSTN(rstn), .START(start), .MEM_WR_EN(mem_wr_en),
    .BR_VALID(br_valid), .BR_PC(br_pc), .BR_MISPRED(br_mispred),
    .CH_PC(ch_pc), .CH_EN(ch_en), .RD_REQ(rd_req), .RD_IDX(rd_idx),
    .RD_ACK(rd_ack), .RD_BR(rd_br), .RD_MISS(rd_miss), .CYCLES(cycles),
    .TOTAL_BR(total_br), .TOTAL_MISS(total_miss), .STATE(state),
    .DONE_P(done_p), .OVF(ovf)
  );

  riscv_perf_monitor #(.N_CH(N_CH), .CNT_W(4), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut_sat (
    .CLK(clk), .RSTN(rstn), .START(start), .MEM_WR_EN(mem_wr_en),
    .BR_VALID(br_valid), .BR_PC(br_pc), .BR_MISPRED(br_mispred),
    .CH_PC(ch_pc), .CH_EN(ch_en), .RD_REQ(rd_req), .RD_IDX(rd_idx),
    .RD_ACK(s_rd_ack), .RD_BR(s_rd_br), .RD_MISS(s_rd_miss), .CYCLES(s_cycles),
    .TOTAL_BR(s_total_br), .TOTAL_MISS(s_total_miss), .STATE(s_state),
    .DONE_P(s_done_p), .OVF(s_ovf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [31:0] pc, input logic mis);
    br_valid   = 1'b1;
    br_pc      = pc;
    br_mispred = mis;
    tick();
    br_valid   = 1'b0;
    br_mispred = 1'b0;
  endtask

  task automatic do_start(input logic wr);
    start     = 1'b1;
    mem_wr_en = wr;
    tick();
    start     = 1'b0;
  endtask

  task automatic read_req(input logic [IDX_W-1:0] idx, input logic [31:0] eb,
                          input logic [31:0] em);
    rd_req = 1'b1;
    rd_idx = idx;
    exp_q.push_back({eb, em});
  endtask

  // Scoreboard: each acknowledge consumes one queued expectation.
  always @(negedge clk) begin
    if (rd_ack) begin
      if (exp_q.size() == 0) begin
        chk("rd_ack_unexpected", 64'd1, 64'd0);
      end else begin
        logic [2*CNT_W-1:0] e;
        e = exp_q.pop_front();
        chk("rd_br", 64'(rd_br), 64'(e[2*CNT_W-1:CNT_W]));
        chk("rd_miss", 64'(rd_miss), 64'(e[CNT_W-1:0]));
      end
    end
  end

  initial begin
    int rb, rm;
    rstn = 1'b1; start = 1'b0; mem_wr_en = 1'b0; br_valid = 1'b0;
    br_pc = '0; br_mispred = 1'b0; ch_pc = '0; ch_en = '0;
    rd_req = 1'b0; rd_idx = '0;

    // Vector table: ten at PC 56 (3 mispredicted), one invalid, four at PC 20 (1 mispredicted)
    for (int i = 0; i < 15; i++) begin
      vecs[i].valid = (i != 10);
      vecs[i].pc    = (i <= 10) ? 32'd56 : 32'd20;
      vecs[i].mis   = (i <= 10) ? ((i % 3 == 1) || i == 10) : (i == 12);
    end
    rb = 0; rm = 0;
    for (int i = 0; i < 15; i++) begin
      rb += int'(vecs[i].valid);
      rm += int'(vecs[i].valid && vecs[i].mis);
      vecs[i].exp_br   = 32'(rb);
      vecs[i].exp_miss = 32'(rm);
    end

    // Reset values
    #2 rstn = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cycles", 64'(cycles), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_done_p", 64'(done_p), 64'd0);
    chk("rst_rd_ack", 64'(rd_ack), 64'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    chk("idle_hold_state", 64'(state), 64'd0);

    // Basic run: 2 quiet cycles, 5 with writes, then the falling edge
    do_start(1'b0);
    chk("start_state", 64'(state), 64'd1);
    repeat (2) tick();
    mem_wr_en = 1'b1;
    repeat (5) tick();
    chk("run_no_done", 64'(state), 64'd1);
    mem_wr_en = 1'b0;
    tick();
    chk("done_state", 64'(state), 64'd2);
    chk("done_p_high", 64'(done_p), 64'd1);
    chk("done_cycles", 64'(cycles), 64'd8);
    branch(32'd20, 1'b1);
    chk("done_p_low", 64'(done_p), 64'd0);
    chk("frozen_cycles", 64'(cycles), 64'd8);
    chk("frozen_total_br", 64'(total_br), 64'd0);
    chk("frozen_state", 64'(state), 64'd2);

    // Channel matching from the vector table
    ch_pc = {32'd0, 32'd56, 32'd56, 32'd20};
    ch_en = 4'b0111;
    do_start(1'b0);
    chk("restart_cycles", 64'(cycles), 64'd0);
    for (int i = 0; i < 15; i++) begin
      br_valid   = vecs[i].valid;
      br_pc      = vecs[i].pc;
      br_mispred = vecs[i].mis;
      tick();
      chk($sformatf("vec%0d_total_br", i), 64'(total_br), 64'(vecs[i].exp_br));
      chk($sformatf("vec%0d_total_miss", i), 64'(total_miss), 64'(vecs[i].exp_miss));
    end
    br_valid = 1'b0; br_mispred = 1'b0;

    // Back-to-back reads, including an out-of-range index
    read_req(4'd0, 32'd4, 32'd1);  tick();
    read_req(4'd1, 32'd10, 32'd3); tick();
    read_req(4'd2, 32'd10, 32'd3); tick();
    read_req(4'd3, 32'd0, 32'd0);  tick();
    read_req(4'd7, 32'd0, 32'd0);  tick();
    // Read coincident with a branch on the same channel sees the old value
    br_valid = 1'b1; br_pc = 32'd20; br_mispred = 1'b1;
    read_req(4'd0, 32'd4, 32'd1);  tick();
    br_valid = 1'b0; br_mispred = 1'b0;
    read_req(4'd0, 32'd5, 32'd2);  tick();
    rd_req = 1'b0;
    tick(); tick();
    chk("rd_hold_br", 64'(rd_br), 64'd5);
    chk("rd_hold_miss", 64'(rd_miss), 64'd2);
    chk("rd_ack_idle", 64'(rd_ack), 64'd0);
    chk("post_rd_total_br", 64'(total_br), 64'd15);
    chk("post_rd_total_miss", 64'(total_miss), 64'd5);

    // START coincident with a falling edge stays in RUN
    mem_wr_en = 1'b1;
    tick();
    do_start(1'b0);
    chk("sim_state", 64'(state), 64'd1);
    chk("sim_total_br", 64'(total_br), 64'd0);
    chk("sim_cycles", 64'(cycles), 64'd0);
    chk("sim_done_p", 64'(done_p), 64'd0);
    tick();
    chk("sim_state2", 64'(state), 64'd1);
    chk("sim_done_p2", 64'(done_p), 64'd0);
    chk("sim_cycles2", 64'(cycles), 64'd1);
    // START with a write in progress, falling edge right after
    do_start(1'b1);
    chk("wr_start_state", 64'(state), 64'd1);
    mem_wr_en = 1'b0;
    tick();
    chk("wr_start_done", 64'(state), 64'd2);
    chk("wr_start_done_p", 64'(done_p), 64'd1);
    chk("wr_start_cycles", 64'(cycles), 64'd1);

    // Saturation on the 4-bit instance
    do_start(1'b0);
    repeat (14) tick();
    chk("sat_cycles14", 64'(s_cycles), 64'd14);
    chk("sat_ovf_low", 64'(s_ovf), 64'd0);
    repeat (6) tick();
    chk("sat_cycles15", 64'(s_cycles), 64'd15);
    chk("sat_ovf_high", 64'(s_ovf), 64'd1);
    chk("main_ovf_low", 64'(ovf), 64'd0);
    do_start(1'b0);
    chk("sat_clear_cycles", 64'(s_cycles), 64'd0);
    chk("sat_clear_ovf", 64'(s_ovf), 64'd0);

    // Reset mid-run
    do_start(1'b0);
    repeat (5) branch(32'(($urandom_range(0, 3)) * 4), 1'b0);
    chk("pre_rst_total_br", 64'(total_br), 64'd5);
    rstn = 1'b0;
    #1;
    chk("mid_rst_total_br", 64'(total_br), 64'd0);
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_cycles", 64'(cycles), 64'd0);
    tick();
    rstn = 1'b1;
    repeat (3) branch(32'd56, 1'b1);
    chk("post_rst_total_br", 64'(total_br), 64'd0);
    chk("post_rst_state", 64'(state), 64'd0);
    chk("post_rst_ch", 64'(cycles), 64'd0);

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_perf_monitor.md
# riscv_perf_monitor

Parametrised performance-statistics unit for the RISC-V cores (v1/v2), instantiated beside the core in the simulation top. It generalises the per-address branch-prediction accounting and the end-of-run detection into a synthesisable block. The block counts cycles, total branches and mispredictions, and per-channel branch and misprediction counts for N_CH watched PCs. The run ends on the first falling edge of the memory write enable after start, and counters are read through a registered request/acknowledge port.

## Interface

Parameters:

- N_CH, 4: number of watched-PC channels, range 1..16.
- CNT_W, 32: width of every counter.
- ADDR_W, 32: PC width.
- IDX_W, 4: width of RD_IDX. Must satisfy 2^IDX_W ≥ N_CH.

Ports:

- CLK, in, 1: clock. Everything is sampled on the rising edge.
- RSTN, in, 1: reset, asynchronous and active-low.
- START, in, 1: clears all counters and OVF, then enters RUN.
- MEM_WR_EN, in, 1: core data-memory write enable. Used only for end-of-run detection.
- BR_VALID, in, 1: a branch resolves this cycle.
- BR_PC, in, ADDR_W: PC of the resolved branch.
- BR_MISPRED, in, 1: the resolved branch was mispredicted. Ignored when BR_VALID=0.
- CH_PC, in, N_CH*ADDR_W: watched PC of channel k, at bits [k*ADDR_W +: ADDR_W].
- CH_EN, in, N_CH: per-channel enable.
- RD_REQ, in, 1: channel read request.
- RD_IDX, in, IDX_W: channel to read.
- RD_ACK, out, 1: read data valid. One-cycle pulse.
- RD_BR, out, CNT_W: branch count of the requested channel.
- RD_MISS, out, CNT_W: misprediction count of the requested channel.
- CYCLES, out, CNT_W: cycles spent in RUN.
- TOTAL_BR, out, CNT_W: all resolved branches.
- TOTAL_MISS, out, CNT_W: all mispredictions.
- STATE, out, 2: 00 IDLE, 01 RUN, 10 DONE.
- DONE_P, out, 1: one-cycle pulse on entry to DONE.
- OVF, out, 1: sticky flag, set when any counter saturates.

## Operation

- **Reset.** All counters 0, STATE=IDLE, OVF=0, DONE_P=0, RD_ACK=0, RD_BR=RD_MISS=0. The internal MEM_WR_EN history register is 0.
- **IDLE.** START → RUN. Counters hold.
- **RUN.**
  - CYCLES increments every cycle.
  - BR_VALID increments TOTAL_BR. BR_VALID&BR_MISPRED also increments TOTAL_MISS.
  - For each channel k with CH_EN[k]=1 and BR_PC==CH_PC[k]: ch_br[k] increments, and ch_miss[k] increments if mispredicted.
  - Several channels may match the same branch; all of them count.
  - A falling edge (history=1, MEM_WR_EN=0) moves the block to DONE and pulses DONE_P the following cycle.
- **DONE.** Counters frozen. START → RUN with a fresh clear.
- **START in any state.**
  - Counters and OVF clear on that edge. Events in the START cycle are not counted.
  - The history register loads the current MEM_WR_EN, so a write in progress does not end the run immediately.
- **START and falling edge in the same cycle.** START wins: the block restarts and stays in RUN, and DONE_P is not asserted.
- **Saturation.** Counters are unsigned and saturate at 2^CNT_W−1; they never wrap. Reaching saturation sets OVF.
- **Reads.**
  - Allowed in any state.
  - A request sampled at an edge returns the channel's counter values as they were before that edge's update.
  - RD_IDX ≥ N_CH returns zeros but is still acknowledged.
  - RD_BR and RD_MISS hold their values until the next acknowledge.

## Timing

- Latency of CYCLES, TOTAL_* and per-channel counters: updated at the edge that samples the event, so visible the next cycle.
- RD_ACK is asserted the cycle after RD_REQ is sampled.
- Back-to-back RD_REQ gives back-to-back RD_ACK, one per request. There is no stall and no backpressure.
- STATE changes at the sampling edge. DONE_P is high for exactly the first cycle STATE=10.
- Falling-edge detection needs MEM_WR_EN=1 for at least one sampled cycle in RUN, or the value loaded at START.
- RSTN asserted mid-run: all outputs return to reset values asynchronously. After RSTN is released the block waits in IDLE for START.

## Test plan

- **Basic run.** Reset, START at cycle 2, MEM_WR_EN 1 for cycles 5–9 then 0 → STATE=10 after the edge that samples the 0, DONE_P high for one cycle, CYCLES=8, counters frozen.
- **Channel matching.** CH_PC={20,56,56,0}, CH_EN=0111. Ten branches at PC 56 with 3 mispredicted, four at PC 20 with 1 mispredicted → reads give ch1 = ch2 = 10/3, ch0 = 4/1, ch3 = 0/0. TOTAL_BR=14, TOTAL_MISS=4.
- **Read interface.** Reads with RD_IDX=1, 2, 7 issued back-to-back → three RD_ACK pulses; idx 7 returns 0/0. A read issued in the same cycle as a branch on that channel returns the pre-update value.
- **Saturation.** CNT_W=4, run 20 cycles → CYCLES=15 and OVF=1. START then clears CYCLES to 0 and OVF to 0.
- **Simultaneous events.** START coinciding with a MEM_WR_EN falling edge in RUN → stays in RUN, counters 0, no DONE_P. START with MEM_WR_EN=1 followed by MEM_WR_EN=0 on the next cycle → DONE.
- **Reset mid-run.** RSTN=0 while TOTAL_BR=5 → outputs zero immediately, STATE=IDLE. Branches arriving before the next START are ignored.
